adder_subtractor_acc: RTL and testbench
=======================================

ADDER_SUBTRACTOR_ACC -- requirements
Module: adder_subtractor_acc

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits; legal range 2..64.
REQ-002 Parameter SAT, default 0, 1 = saturate result on signed overflow, 0 = wrap.
REQ-003 Clock and reset: one clock, clk; reset rst is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 A  input  WIDTH  first operand, used when Acc=0.
REQ-007 B  input  WIDTH  second operand.
REQ-008 Op  input  1  0 = add, 1 = subtract (first operand minus B).
REQ-009 Acc  input  1  1 = accumulator register replaces A as first operand.
REQ-010 Clr  input  1  clears accumulator on the cycle it is high.
REQ-011 In_valid  input  1  operands/controls valid this cycle.
REQ-012 In_ready  output  1  block can accept a transaction this cycle.
REQ-013 Sum  output  WIDTH  registered result.
REQ-014 Cout  output  1  carry out of the two's-complement adder (subtract: 1 = no borrow).
REQ-015 Ovf  output  1  signed overflow of the operation.
REQ-016 Zero  output  1  Sum equals 0.
REQ-017 Out_valid  output  1  Sum/Cout/Ovf/Zero hold a valid result.
REQ-018 Out_ready  input  1  consumer accepts the result this cycle.

Function
REQ-019 Transaction accepted on a rising edge when In_valid=1 and In_ready=1.
REQ-020 In_ready shall equal (!Out_valid || Out_ready), combinationally; no other dependency.
REQ-021 Result registered one cycle after acceptance: Out_valid=1 in cycle following accept.
REQ-022 Raw result: X + (Op ? ~B : B) + Op, computed at WIDTH+1 bits; Cout = bit WIDTH.
REQ-023 X = A when Acc=0; X = accumulator when Acc=1; X = 0 when Acc=1 and Clr=1 same cycle.
REQ-024 Ovf = 1 when X and the effective B operand share a sign bit and raw result sign differs.
REQ-025 SAT=0: Sum = raw result bits [WIDTH-1:0].
REQ-026 SAT=1 and Ovf=1: Sum = most positive (0 then all 1s) if X sign was 0, else most negative (1 then all 0s); Cout and Ovf still reflect raw computation.
REQ-027 Zero computed from final (post-saturation) Sum.
REQ-028 Accumulator (WIDTH bits) loads final Sum on every accepted transaction, regardless of Acc.
REQ-029 Clr=1 without an accepted transaction: accumulator becomes 0 next edge; outputs unchanged.
REQ-030 Clr=1 with an accepted transaction: REQ-023 applies, accumulator loads that result.
REQ-031 Out_valid=1 and Out_ready=0: Sum, Cout, Ovf, Zero, Out_valid held stable; In_ready=0.
REQ-032 Out_valid=1, Out_ready=1, In_valid=1: new result replaces old next edge, Out_valid stays 1 (full throughput, one per cycle).
REQ-033 Out_valid=1, Out_ready=1, In_valid=0: Out_valid falls to 0 next edge.
REQ-034 In_valid=0: operand, Op, Acc inputs ignored; accumulator unchanged except by Clr.

Reset
REQ-035 rst=1 at an edge: Out_valid=0, Sum=0, Cout=0, Ovf=0, Zero=0, accumulator=0.
REQ-036 rst overrides every other input, including In_valid and Clr, and discards any pending result.
REQ-037 In_ready=1 during and after reset (Out_valid=0).

Verification
REQ-038 WIDTH=8, SAT=0: A=0x0F, B=0x01, Op=0 -> Sum=0x10, Cout=0, Ovf=0, Zero=0; Op=1 -> Sum=0x0E, Cout=1.
REQ-039 WIDTH=8: A=0xFF, B=0x01, Op=0 -> Sum=0x00, Cout=1, Zero=1; Op=1 -> Sum=0xFE, Cout=1, Ovf=0.
REQ-040 WIDTH=8: A=0x7F, B=0x01, Op=0 -> SAT=0 Sum=0x80, Ovf=1; SAT=1 Sum=0x7F, Ovf=1; A=0x80, B=0x01, Op=1, SAT=1 -> Sum=0x80, Ovf=1.
REQ-041 Accumulate: Clr+Acc with B=0x05 add, then Acc with B=0x03 add, then Acc with B=0x02 subtract -> Sums 0x05, 0x08, 0x06 on consecutive cycles.
REQ-042 Backpressure: Out_ready=0 for 3 cycles with In_valid=1 -> In_ready=0, outputs stable, accumulator unchanged; release -> one result per cycle, none lost or duplicated.
REQ-043 Reset mid-stream: rst asserted while Out_valid=1 and Out_ready=0 -> next cycle Out_valid=0, accumulator=0, In_ready=1.

Source files
------------

// File: rtl/adder_subtractor_acc.sv
// Registered add/subtract unit with an internal accumulator, optional signed
// saturation and a valid/ready handshake on both sides (one result per cycle).
module adder_subtractor_acc #(
  parameter int WIDTH = 8,
  parameter bit SAT   = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Op,
  input  logic             Acc,
  input  logic             Clr,
  input  logic             In_valid,
  output logic             In_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf,
  output logic             Zero,
  output logic             Out_valid,
  input  logic             Out_ready
);

  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MAX_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH-1:0] acc_r;
  logic [WIDTH-1:0] sum_r;
  logic             cout_r;
  logic             ovf_r;
  logic             zero_r;
  logic             out_valid_r;

  logic [WIDTH-1:0] x_s;
  logic [WIDTH-1:0] b_eff_s;
  logic [WIDTH:0]   raw_s;
  logic             ovf_s;
  logic [WIDTH-1:0] sum_s;
  logic             accept_s;

  // Ready whenever the output slot is empty or being drained this cycle.
  assign In_ready = !out_valid_r || Out_ready;
  assign accept_s = In_valid && In_ready;

  // Operand selection, two's-complement add/subtract and saturation.
  always_comb begin
    x_s = A;
    if (Acc) begin
      if (Clr) begin
        x_s = {WIDTH{1'b0}};
      end else begin
        x_s = acc_r;
      end
    end else begin
      x_s = A;
    end
    b_eff_s = Op ? ~B : B;
    raw_s   = {1'b0, x_s} + {1'b0, b_eff_s} + {{WIDTH{1'b0}}, Op};
    ovf_s   = (x_s[WIDTH-1] == b_eff_s[WIDTH-1]) && (raw_s[WIDTH-1] != x_s[WIDTH-1]);
    // Overflow direction follows the sign of the first operand.
    if (SAT && ovf_s) begin
      if (x_s[WIDTH-1]) begin
        sum_s = MAX_NEG;
      end else begin
        sum_s = MAX_POS;
      end
    end else begin
      sum_s = raw_s[WIDTH-1:0];
    end
  end

  // Result registers, output handshake and accumulator.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_r       <= {WIDTH{1'b0}};
      sum_r       <= {WIDTH{1'b0}};
      cout_r      <= 1'b0;
      ovf_r       <= 1'b0;
      zero_r      <= 1'b0;
      out_valid_r <= 1'b0;
    end else if (accept_s) begin
      acc_r       <= sum_s;
      sum_r       <= sum_s;
      cout_r      <= raw_s[WIDTH];
      ovf_r       <= ovf_s;
      zero_r      <= (sum_s == {WIDTH{1'b0}});
      out_valid_r <= 1'b1;
    end else begin
      if (Clr) begin
        acc_r <= {WIDTH{1'b0}};
      end else begin
        acc_r <= acc_r;
      end
      if (Out_ready) begin
        out_valid_r <= 1'b0;
      end else begin
        out_valid_r <= out_valid_r;
      end
    end
  end

  assign Sum       = sum_r;
  assign Cout      = cout_r;
  assign Ovf       = ovf_r;
  assign Zero      = zero_r;
  assign Out_valid = out_valid_r;

endmodule

// File: tb/tb_adder_subtractor_acc.sv
// Bench for adder_subtractor_acc: a wrapping and a saturating instance share
// stimulus; directed scenarios plus a random run against an integer-arithmetic model.
module tb_adder_subtractor_acc;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;
  logic       op = 1'b0;
  logic       acc = 1'b0;
  logic       clr = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;

  logic [1:0] in_ready;
  logic [1:0] cout;
  logic [1:0] ovf;
  logic [1:0] zero;
  logic [1:0] out_valid;
  logic [7:0] sum0;
  logic [7:0] sum1;

  int total = 0;
  int bad = 0;
  bit mon_en = 1'b0;

  logic [7:0]  accm [2];
  logic [10:0] expq0 [$];
  logic [10:0] expq1 [$];

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic       op;
    logic [7:0] s0;
    logic       c;
    logic       v;
    logic       z;
    logic [7:0] s1;
  } vec_t;
  vec_t vecs [6];

  always #5 clk = ~clk;

  adder_subtractor_acc #(.WIDTH(8), .SAT(1'b0)) dut_wrap (
    .clk(clk), .rst(rst), .A(a), .B(b), .Op(op), .Acc(acc), .Clr(clr),
    .In_valid(in_valid), .In_ready(in_ready[0]), .Sum(sum0), .Cout(cout[0]),
    .Ovf(ovf[0]), .Zero(zero[0]), .Out_valid(out_valid[0]), .Out_ready(out_ready)
  );

  adder_subtractor_acc #(.WIDTH(8), .SAT(1'b1)) dut_sat (
    .clk(clk), .rst(rst), .A(a), .B(b), .Op(op), .Acc(acc), .Clr(clr),
    .In_valid(in_valid), .In_ready(in_ready[1]), .Sum(sum1), .Cout(cout[1]),
    .Ovf(ovf[1]), .Zero(zero[1]), .Out_valid(out_valid[1]), .Out_ready(out_ready)
  );

  // Reference: signed/unsigned integer arithmetic, returns {cout, ovf, zero, sum}.
  function automatic logic [10:0] model(input logic [7:0] x, input logic [7:0] y,
                                        input logic sub, input bit sat);
    int xu;
    int yu;
    int xs;
    int ys;
    int res;
    logic c;
    logic v;
    logic [7:0] s;
    xu  = x;
    yu  = y;
    xs  = $signed(x);
    ys  = $signed(y);
    res = sub ? (xs - ys) : (xs + ys);
    c   = sub ? (xu >= yu) : ((xu + yu) > 255);
    v   = (res > 127) || (res < -128);
    if (sat && v) s = (res > 127) ? 8'h7F : 8'h80;
    else          s = res[7:0];
    return {c, v, (s == 8'h00), s};
  endfunction

  // Scoreboard: check outputs against queued expectations, then predict the next edge.
  always @(negedge clk) begin
    if (mon_en) begin
      logic [10:0] got [2];
      bit ev [2];
      logic [7:0] x;
      got[0] = {cout[0], ovf[0], zero[0], sum0};
      got[1] = {cout[1], ovf[1], zero[1], sum1};
      ev[0]  = (expq0.size() != 0);
      ev[1]  = (expq1.size() != 0);
      for (int s = 0; s < 2; s++) begin
        total++;
        if (out_valid[s] !== ev[s]) begin
          bad++;
          $display("FAIL mon_out_valid[%0d] got=%b exp=%b t=%0t", s, out_valid[s], ev[s], $time);
        end
        total++;
        if (in_ready[s] !== (!ev[s] || out_ready)) begin
          bad++;
          $display("FAIL mon_in_ready[%0d] got=%b exp=%b t=%0t", s, in_ready[s], (!ev[s] || out_ready), $time);
        end
        if (ev[s]) begin
          total++;
          if (got[s] !== ((s == 0) ? expq0[0] : expq1[0])) begin
            bad++;
            $display("FAIL mon_result[%0d] got=%h exp=%h t=%0t", s, got[s],
                     (s == 0) ? expq0[0] : expq1[0], $time);
          end
        end
      end
      if (rst) begin
        expq0.delete();
        expq1.delete();
        accm[0] = 8'h00;
        accm[1] = 8'h00;
      end else begin
        for (int s = 0; s < 2; s++) begin
          logic [10:0] r;
          bit take;
          take = in_valid && (!ev[s] || out_ready);
          if (ev[s] && out_ready) begin
            if (s == 0) void'(expq0.pop_front());
            else        void'(expq1.pop_front());
          end
          if (take) begin
            x = acc ? (clr ? 8'h00 : accm[s]) : a;
            r = model(x, b, op, (s == 1));
            if (s == 0) expq0.push_back(r);
            else        expq1.push_back(r);
            accm[s] = r[7:0];
          end else if (clr) begin
            accm[s] = 8'h00;
          end
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b1;
    clr = 1'b1;
    cyc();
    cyc();
    total++;
    if (out_valid !== 2'b00 || sum0 !== 8'h00 || sum1 !== 8'h00 || cout !== 2'b00 ||
        ovf !== 2'b00 || zero !== 2'b00) begin
      bad++;
      $display("FAIL reset_outputs got v=%b s0=%h s1=%h c=%b o=%b z=%b exp all zero",
               out_valid, sum0, sum1, cout, ovf, zero);
    end
    total++;
    if (in_ready !== 2'b11) begin
      bad++;
      $display("FAIL reset_in_ready got=%b exp=11", in_ready);
    end
    in_valid = 1'b0;
    clr = 1'b0;
    accm[0] = 8'h00;
    accm[1] = 8'h00;
    mon_en = 1'b1;
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_arith();
    vecs[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0, 1'b0, 8'h10};
    vecs[1] = '{8'h0F, 8'h01, 1'b1, 8'h0E, 1'b1, 1'b0, 1'b0, 8'h0E};
    vecs[2] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h00};
    vecs[3] = '{8'hFF, 8'h01, 1'b1, 8'hFE, 1'b1, 1'b0, 1'b0, 8'hFE};
    vecs[4] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0, 8'h7F};
    vecs[5] = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0, 8'h80};
    out_ready = 1'b1;
    in_valid = 1'b1;
    acc = 1'b0;
    clr = 1'b0;
    for (int i = 0; i < 6; i++) begin
      a  = vecs[i].a;
      b  = vecs[i].b;
      op = vecs[i].op;
      cyc();
      total++;
      if (out_valid !== 2'b11 || sum0 !== vecs[i].s0 || sum1 !== vecs[i].s1) begin
        bad++;
        $display("FAIL arith_sum[%0d] got v=%b s0=%h s1=%h exp v=11 s0=%h s1=%h",
                 i, out_valid, sum0, sum1, vecs[i].s0, vecs[i].s1);
      end
      total++;
      if (cout !== {2{vecs[i].c}} || ovf !== {2{vecs[i].v}} || zero !== {2{vecs[i].z}}) begin
        bad++;
        $display("FAIL arith_flags[%0d] got c=%b o=%b z=%b exp c=%b o=%b z=%b",
                 i, cout, ovf, zero, vecs[i].c, vecs[i].v, vecs[i].z);
      end
    end
    in_valid = 1'b0;
    cyc();
  endtask

  task automatic test_accumulate();
    logic [7:0] bs [3];
    logic [7:0] ex [3];
    bs[0] = 8'h05; bs[1] = 8'h03; bs[2] = 8'h02;
    ex[0] = 8'h05; ex[1] = 8'h08; ex[2] = 8'h06;
    out_ready = 1'b1;
    in_valid = 1'b1;
    acc = 1'b1;
    for (int i = 0; i < 3; i++) begin
      clr = (i == 0);
      op  = (i == 2);
      b   = bs[i];
      a   = 8'($urandom);
      cyc();
      total++;
      if (out_valid !== 2'b11 || sum0 !== ex[i] || sum1 !== ex[i]) begin
        bad++;
        $display("FAIL accumulate[%0d] got v=%b s0=%h s1=%h exp %h", i, out_valid, sum0, sum1, ex[i]);
      end
    end
    // Idle clear: outputs keep last Sum, accumulator restarts from zero.
    in_valid = 1'b0;
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    total++;
    if (out_valid !== 2'b00 || sum0 !== 8'h06) begin
      bad++;
      $display("FAIL idle_clear_hold got v=%b s0=%h exp v=00 s0=06", out_valid, sum0);
    end
    in_valid = 1'b1;
    op = 1'b0;
    b = 8'h11;
    cyc();
    in_valid = 1'b0;
    acc = 1'b0;
    total++;
    if (sum0 !== 8'h11 || sum1 !== 8'h11) begin
      bad++;
      $display("FAIL idle_clear_acc got s0=%h s1=%h exp 11", sum0, sum1);
    end
    cyc();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid = 1'b1;
    acc = 1'b0;
    op = 1'b0;
    a = 8'h20;
    b = 8'h03;
    cyc();
    a = 8'h40;
    for (int i = 0; i < 3; i++) begin
      cyc();
      total++;
      if (in_ready !== 2'b00 || out_valid !== 2'b11 || sum0 !== 8'h23 || sum1 !== 8'h23) begin
        bad++;
        $display("FAIL stall[%0d] got rdy=%b v=%b s0=%h s1=%h exp rdy=00 v=11 s=23",
                 i, in_ready, out_valid, sum0, sum1);
      end
    end
    out_ready = 1'b1;
    #1;
    total++;
    if (in_ready !== 2'b11) begin
      bad++;
      $display("FAIL release_ready got=%b exp=11", in_ready);
    end
    cyc();
    total++;
    if (out_valid !== 2'b11 || sum0 !== 8'h43) begin
      bad++;
      $display("FAIL release_first got v=%b s0=%h exp v=11 s0=43", out_valid, sum0);
    end
    acc = 1'b1;
    b = 8'h00;
    cyc();
    total++;
    if (out_valid !== 2'b11 || sum0 !== 8'h43) begin
      bad++;
      $display("FAIL release_acc got v=%b s0=%h exp v=11 s0=43", out_valid, sum0);
    end
    in_valid = 1'b0;
    acc = 1'b0;
    cyc();
    total++;
    if (out_valid !== 2'b00) begin
      bad++;
      $display("FAIL drain got v=%b exp=00", out_valid);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    in_valid = 1'b1;
    a = 8'h55;
    b = 8'h01;
    op = 1'b0;
    acc = 1'b0;
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    total++;
    if (out_valid !== 2'b00 || in_ready !== 2'b11) begin
      bad++;
      $display("FAIL reset_mid got v=%b rdy=%b exp v=00 rdy=11", out_valid, in_ready);
    end
    out_ready = 1'b1;
    acc = 1'b1;
    b = 8'h09;
    cyc();
    in_valid = 1'b0;
    acc = 1'b0;
    total++;
    if (sum0 !== 8'h09 || sum1 !== 8'h09) begin
      bad++;
      $display("FAIL reset_mid_acc got s0=%h s1=%h exp 09", sum0, sum1);
    end
    cyc();
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      rst       = ($urandom_range(0, 59) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      a         = 8'($urandom);
      b         = 8'($urandom);
      op        = 1'($urandom);
      acc       = 1'($urandom);
      clr       = ($urandom_range(0, 7) == 0);
      cyc();
    end
    rst = 1'b0;
    in_valid = 1'b0;
    clr = 1'b0;
    out_ready = 1'b1;
    cyc();
    cyc();
  endtask

  initial begin
    test_reset();
    test_arith();
    test_accumulate();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
